// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_pkg                                                       |
// | Purpose  : Shared types and helpers for the load/store data memory.      |
// |            mem_size_t  - access size encoding (byte/half/word/illegal)   |
// |            mem_state_t - controller state (CLEAR sweep, READY)           |
// |            lane_mask() - byte-enable mask for a size and byte lane       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } mem_size_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  // Byte-enable mask for an access. A half uses lane[1] only: the low bit is
  // a misalignment that the caller flags as an error and never writes.
  function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = 4'b0001 << lane;
      SIZE_H:  m = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_lane_align                                                |
// | Purpose  : Combinational byte-lane steering for the data memory.         |
// |            Store side: replicates right-aligned store data across lanes  |
// |            and produces the byte-enable mask.                            |
// |            Load side: extracts the addressed byte/half from a word and   |
// |            sign- or zero-extends it to 32 bits.                          |
// | Ports    : st_size_i, st_lane_i, st_wdata_i -> st_wdata_o, st_mask_o     |
// |            ld_size_i, ld_lane_i, ld_unsigned_i, ld_word_i -> ld_data_o   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_mask_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Replicating the data into every lane lets the mask alone pick the lanes.
  always_comb begin
    st_mask_o = lane_mask(mem_size_t'(st_size_i), st_lane_i);
    case (mem_size_t'(st_size_i))
      SIZE_B:  st_wdata_o = {4{st_wdata_i[7:0]}};
      SIZE_H:  st_wdata_o = {2{st_wdata_i[15:0]}};
      default: st_wdata_o = st_wdata_i;
    endcase
  end

  always_comb begin
    case (ld_lane_i)
      2'd0:    w_byte = ld_word_i[7:0];
      2'd1:    w_byte = ld_word_i[15:8];
      2'd2:    w_byte = ld_word_i[23:16];
      default: w_byte = ld_word_i[31:24];
    endcase
    w_half = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    w_sign = 1'b0;
    case (mem_size_t'(ld_size_i))
      SIZE_B: begin
        w_sign    = w_byte[7] & ~ld_unsigned_i;
        ld_data_o = {{24{w_sign}}, w_byte};
      end
      SIZE_H: begin
        w_sign    = w_half[15] & ~ld_unsigned_i;
        ld_data_o = {{16{w_sign}}, w_half};
      end
      SIZE_W:  ld_data_o = ld_word_i;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                 |
// | Purpose  : Single-port data memory for the core load/store path.         |
// |            Byte/half/word accesses over valid/ready, byte-lane merged    |
// |            stores, extended loads, one response per request. Contents    |
// |            are cleared one word per cycle after reset.                   |
// | Ports    : clock, reset (async, active-high)                             |
// |            req_valid/req_ready/req_write/req_size/req_unsigned/          |
// |            req_addr/req_wdata - request channel                          |
// |            rsp_valid/rsp_rdata/rsp_error - response (no backpressure)    |
// |            busy - clear sweep in progress                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  localparam int                 C_IDX_W    = $clog2(DEPTH);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(DEPTH - 1);

  logic [31:0] mem_q [DEPTH];

  mem_state_t         state_q;
  logic [C_IDX_W-1:0] clr_idx_q;
  logic               ready_q;
  logic               busy_q;

  // Stage 1: request captured at its accepting edge, word read alongside.
  logic               s1_valid_q;
  logic               s1_write_q;
  logic               s1_err_q;
  logic [1:0]         s1_size_q;
  logic [1:0]         s1_lane_q;
  logic               s1_unsigned_q;
  logic [31:0]        s1_word_q;

  // Stage 2: registered response.
  logic               rsp_valid_q;
  logic               rsp_error_q;
  logic [31:0]        rsp_rdata_q;
  logic [31:0]        rsp_rdata_d;

  logic               w_accept;
  logic [1:0]         w_lane;
  logic [C_IDX_W-1:0] w_idx;
  logic               w_oor;
  logic               w_err;
  logic [31:0]        w_wdata_rep;
  logic [3:0]         w_mask;
  logic [31:0]        w_ld_data;

  assign w_accept = req_valid & ready_q;
  assign w_lane   = req_addr[1:0];
  assign w_idx    = req_addr[C_IDX_W+1:2];
  // Any set bit above the word index means the address is >= 4*DEPTH.
  assign w_oor    = |(req_addr >> (C_IDX_W + 2));

  always_comb begin
    w_err = w_oor;
    case (mem_size_t'(req_size))
      SIZE_H:   w_err = w_err | w_lane[0];
      SIZE_W:   w_err = w_err | (|w_lane);
      SIZE_ILL: w_err = 1'b1;
      default:  w_err = w_err;
    endcase
  end

  mem_lane_align u_align (
    .st_size_i     (req_size),
    .st_lane_i     (w_lane),
    .st_wdata_i    (req_wdata),
    .st_wdata_o    (w_wdata_rep),
    .st_mask_o     (w_mask),
    .ld_size_i     (s1_size_q),
    .ld_lane_i     (s1_lane_q),
    .ld_unsigned_i (s1_unsigned_q),
    .ld_word_i     (s1_word_q),
    .ld_data_o     (w_ld_data)
  );

  // Stores and errored requests answer with zero data.
  assign rsp_rdata_d = (s1_valid_q && !s1_write_q && !s1_err_q) ? w_ld_data : 32'h0;

  // Array port: no reset on the storage itself; the sweep does the clearing.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem_q[clr_idx_q] <= 32'h0;
    end else if (w_accept && req_write && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (w_mask[l]) begin
          mem_q[w_idx][8*l +: 8] <= w_wdata_rep[8*l +: 8];
        end
      end
    end
    if (w_accept) begin
      s1_word_q <= mem_q[w_idx];
    end
  end

  // Clear FSM and request/response pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b1;
      s1_valid_q    <= 1'b0;
      s1_write_q    <= 1'b0;
      s1_err_q      <= 1'b0;
      s1_size_q     <= 2'b00;
      s1_lane_q     <= 2'b00;
      s1_unsigned_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_idx_q == C_LAST_IDX) begin
            state_q   <= READY;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      s1_valid_q <= w_accept;
      if (w_accept) begin
        s1_write_q    <= req_write;
        s1_err_q      <= w_err;
        s1_size_q     <= req_size;
        s1_lane_q     <= w_lane;
        s1_unsigned_q <= req_unsigned;
      end

      rsp_valid_q <= s1_valid_q;
      rsp_error_q <= s1_valid_q & s1_err_q;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_ctrl                                              |
// | Purpose  : Scoreboard bench for data_mem_ctrl (DEPTH=16). Stimulus pushes |
// |            hand-computed responses; a monitor pops them on rsp_valid.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_data_mem_ctrl;

  localparam int         DEPTH  = 16;
  localparam int         ADDR_W = 32;
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_I   = 2'b11;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              busy;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   run_len = 0;
  int   max_run = 0;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_rsp: got err=%0b data=%h, required no response",
                   rsp_error, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_error !== e.err || rsp_rdata !== e.data) begin
            n_miss++;
            $display("FAIL %s: got err=%0b data=%h, required err=%0b data=%h",
                     e.name, rsp_error, rsp_rdata, e.err, e.data);
          end
        end
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Called at posedge+1; request is accepted at the next edge.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] edata);
    exp_t e;
    e.name = name;
    e.err  = eerr;
    e.data = edata;
    exp_q.push_back(e);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Counts edges after reset release until req_ready; drops any request held.
  task automatic wait_ready(input string name);
    int cnt = 0;
    do begin
      @(posedge clock); #1;
      cnt++;
      chk({name, "_busy"}, busy, !req_ready);
    end while (!req_ready && cnt < 4 * DEPTH);
    req_valid = 1'b0;
    chk(name, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    idle(3);
    chk("rst_ready",     req_ready, 1'b0);
    chk("rst_busy",      busy,      1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    reset = 1'b0;
    wait_ready("clear_len");

    for (int i = 0; i < DEPTH; i++)
      issue($sformatf("clr_rd%0d", i), 1'b0, SZ_W, 1'b0, 32'(i * 4), 32'h0, 1'b0, 32'h0);
    drain();

    issue("sw_10",  1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue("sb_11",  1'b1, SZ_B, 1'b1, 32'h11, 32'hAAAAAA55, 1'b0, 32'h0);
    issue("lw_10",  1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);
    issue("lb_13",  1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE);
    issue("lbu_13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE);
    issue("lb_10",  1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);
    issue("lb_11",  1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000055);
    issue("lw_uns", 1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);

    issue("sh_22",  1'b1, SZ_H, 1'b0, 32'h22, 32'h12348001, 1'b0, 32'h0);
    issue("lh_22",  1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF8001);
    issue("lhu_22", 1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00008001);
    issue("lh_21",  1'b0, SZ_H, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0);
    issue("lw_20",  1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80010000);
    issue("lh_20",  1'b0, SZ_H, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00000000);

    issue("sw_06_mis", 1'b1, SZ_W, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("sz_ill",    1'b1, SZ_I, 1'b0, 32'h08, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("sw_oor",    1'b1, SZ_W, 1'b0, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("sh_23_mis", 1'b1, SZ_H, 1'b0, 32'h23, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("lw_oor",    1'b0, SZ_W, 1'b0, 32'h44, 32'h0, 1'b1, 32'h0);
    issue("lw_04",     1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    issue("lw_08",     1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0);
    issue("lw_00",     1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
    issue("lw_20_chk", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80010000);
    issue("sw_3c",     1'b1, SZ_W, 1'b0, 32'h3C, 32'hCAFEF00D, 1'b0, 32'h0);
    issue("lw_3c",     1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 1'b0, 32'hCAFEF00D);
    drain();

    idle(3);
    max_run = 0;
    issue("b2b_sw1", 1'b1, SZ_W, 1'b0, 32'h0, 32'h1, 1'b0, 32'h0);
    issue("b2b_lw1", 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1);
    issue("b2b_sw2", 1'b1, SZ_W, 1'b0, 32'h0, 32'h2, 1'b0, 32'h0);
    issue("b2b_lw2", 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2);
    drain();
    idle(2);
    chk("b2b_pulses", 32'(max_run), 32'd4);

    issue("sw_04", 1'b1, SZ_W, 1'b0, 32'h04, 32'h12345678, 1'b0, 32'h0);
    drain();
    idle(2);
    // Load accepted at the next edge; reset lands before its response.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = SZ_W;
    req_addr  = 32'h04;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #3;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    idle(2);
    chk("midrst_rsp_valid2", rsp_valid, 1'b0);
    chk("midrst_ready",      req_ready, 1'b0);
    chk("midrst_busy",       busy,      1'b1);
    // A store held during the sweep must be ignored.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = SZ_W;
    req_addr  = 32'h04;
    req_wdata = 32'hFFFFFFFF;
    reset     = 1'b0;
    wait_ready("reclear_len");
    issue("post_lw_04", 1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    issue("post_lw_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    issue("post_lw_3c", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0);
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory for the RISC-V core's load/store path. It accepts byte/half/word requests over a valid/ready handshake, merges store data by byte lane, and returns sign- or zero-extended load data with one-cycle registered latency. After reset it clears its contents one word per cycle, so a large array is never reset in a single cycle. It sits between the execute-stage load/store logic and the register-file writeback mux.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 2.
- `ADDR_W`, 32: byte-address width; must satisfy ADDR_W ≥ log2(DEPTH)+2.
- `clock` in 1: rising-edge clock for all state.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend load (LBU/LHU); ignored for word and for stores.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and for errors.
- `rsp_error` out 1: request was misaligned, out of range, or had an illegal size.
- `busy` out 1: clear sweep in progress.

## Operation
- States: CLEAR, READY.
- CLEAR: writes 0 to word index `clr_idx`, then increments it, once per cycle. When DEPTH−1 has been written, the block moves to READY. In CLEAR, `req_ready`=0 and `busy`=1.
- READY: `req_ready`=1 and `busy`=0. A request is accepted when `req_valid && req_ready`.
- Word index = `req_addr[log2(DEPTH)+1:2]`. Byte lane = `req_addr[1:0]`.
- Error conditions, any of which sets `rsp_error`:
  - size 11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `req_addr` ≥ 4·DEPTH.
- On error: no array write and `rsp_rdata`=0.
- Store: only the addressed lanes are written. Byte writes lane `addr[1:0]`; half writes lanes `addr[1]`*2 and +1; word writes all four lanes. Other lanes are preserved.
- Load: the addressed byte or half is shifted to bit 0, then sign-extended (or zero-extended when `req_unsigned`). Word loads return the full word.
- A load after a store to the same word returns the merged data. The array updates at the store's accepting edge.

## Timing
- Reset values: `req_ready`=0, `busy`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, state=CLEAR, `clr_idx`=0.
- Clear duration: exactly DEPTH cycles after reset deasserts. `req_ready` rises in cycle DEPTH, counting the first post-reset edge as cycle 1.
- Latency: a request accepted at edge N produces `rsp_valid`=1, `rsp_rdata` and `rsp_error` after edge N+1, held for one cycle.
- Every request gets exactly one response, stores included (acknowledge). `rsp_valid` drops back to 0 unless another request was accepted.
- Throughput: one request per cycle; back-to-back requests are fully pipelined.
- There is no backpressure on the response; the consumer always accepts it.
- Reset mid-operation (CLEAR or READY): any pending response is discarded (`rsp_valid`=0 immediately), and the clear sweep restarts from index 0.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Structure
- Package `mem_pkg` contains:
  - `mem_size_t` enum (SIZE_B, SIZE_H, SIZE_W, SIZE_ILL);
  - `mem_state_t` enum (CLEAR, READY);
  - function `lane_mask(size, addr[1:0])` returning the 4-bit byte mask.
- Sub-module `mem_lane_align` (combinational) handles store-data replication and byte-mask generation, plus load extraction and extension. It is instantiated once in `data_mem_ctrl`.
- The array and the clear FSM live in the top module.

## Test plan
- Reset, then count cycles: `req_ready`=0 for exactly DEPTH cycles, then 1; reading every word in DEPTH=16 mode returns 0.
- SW 0xDEADBEEF @0x10; SB 0x55 @0x11; LW @0x10 → 0xDEAD55EF; LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE.
- SH 0x8001 @0x22; LH @0x22 → 0xFFFF8001; LHU @0x22 → 0x00008001; LH @0x21 → `rsp_error`=1, rdata 0, memory unchanged.
- Misaligned SW @0x06, size 11, and address 4·DEPTH each → `rsp_error`=1; a later LW of the touched words shows no change.
- Back-to-back SW @0x0 = 1, LW @0x0, SW @0x0 = 2, LW @0x0 over 4 consecutive cycles → 4 consecutive `rsp_valid` pulses; the loads return 1 and 2.
- Assert `reset` in the cycle after a load is accepted → no `rsp_valid`; the sweep restarts; previously stored data reads 0 after the clear completes.
